// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds, occupancy count and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise dout is registered with 1-cycle latency.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_wr, do_rd;

    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_THRESH);
    assign almost_empty = count <= CW'(AE_THRESH);
    assign do_wr        = wr && !full;
    assign do_rd        = rd && !empty;

    // storage is deliberately left out of reset; count=0 hides stale words
    always_ff @(posedge clk)
        if (do_wr) mem[wptr] <= din;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= do_wr ? wptr + 1'b1 : wptr;
            rptr      <= do_rd ? rptr + 1'b1 : rptr;
            count     <= count + CW'(do_wr) - CW'(do_rd);
            overflow  <= wr && full;
            underflow <= rd && empty;
        end

`ifdef FIFO_FWFT_EN
    assign dout = empty ? '0 : mem[rptr];
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) dout_q <= '0;
        else if (do_rd) dout_q <= mem[rptr];

    assign dout = dout_q;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (standard or FIFO_FWFT_EN build).
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst, wr, rd;
    logic [7:0] din, dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q [$];

    sync_fifo_param dut (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        wr = 1'b1;
        din = d;
        tick();
        wr = 1'b0;
    endtask

    // standard mode: data follows the rd edge; fwft mode: head is visible before the pop
    task automatic read_word(input logic [7:0] exp, input string tag);
`ifdef FIFO_FWFT_EN
        chk(tag, dout, exp);
`endif
        rd = 1'b1;
        tick();
        rd = 1'b0;
`ifndef FIFO_FWFT_EN
        chk(tag, dout, exp);
`endif
    endtask

    initial begin
        int sent, cyc;
        logic w, r;
        rst = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        #3;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_dout", dout, 0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) write_word(8'h11 + 8'(i));
        chk("t1_count5", count, 5);
        read_word(8'h11, "t1_read");
        chk("t1_dout_nz", dout, 8'h12 - (`ifdef FIFO_FWFT_EN 0 `else 1 `endif));
        rst = 1'b0;
        #1;
        chk("t1_async_count", count, 0);
        chk("t1_async_empty", empty, 1);
        chk("t1_async_dout", dout, 0);
        #2 rst = 1'b1;
        tick();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t1_underflow", underflow, 1);
        chk("t1_count_after_uf", count, 0);
        tick();
        chk("t1_underflow_clr", underflow, 0);

        for (int i = 0; i < 16; i++) begin
            write_word(8'(i));
            chk("t2_count", count, i + 1);
            chk("t2_af", almost_full, (i + 1) >= 14);
            chk("t2_ae", almost_empty, (i + 1) <= 2);
        end
        chk("t2_full", full, 1);
        write_word(8'hAA);
        chk("t2_overflow", overflow, 1);
        chk("t2_count16", count, 16);
        tick();
        chk("t2_overflow_clr", overflow, 0);

        for (int i = 0; i < 16; i++) begin
            read_word(8'(i), "t3_data");
            chk("t3_count", count, 15 - i);
            chk("t3_ae", almost_empty, (15 - i) <= 2);
        end
        chk("t3_empty", empty, 1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t3_underflow", underflow, 1);
`ifdef FIFO_FWFT_EN
        chk("t3_dout_empty", dout, 0);
`else
        chk("t3_dout_hold", dout, 8'h0F);
`endif
        tick();
        chk("t3_underflow_clr", underflow, 0);

        sent = 0;
        cyc = 0;
        while ((sent < 40 || q.size() > 0) && cyc < 400) begin
            w = sent < 40 && q.size() < 16;
            r = q.size() > 0 && ($urandom_range(0, 1) == 1 || sent >= 40);
            wr = w;
            rd = r;
            din = 8'(8'h80 + sent);
`ifdef FIFO_FWFT_EN
            if (r) chk("t4_data", dout, q[0]);
`endif
            tick();
            if (w) begin q.push_back(din); sent++; end
            if (r) begin
`ifndef FIFO_FWFT_EN
                chk("t4_data", dout, q[0]);
`endif
                void'(q.pop_front());
            end
            chk("t4_count", count, q.size());
            cyc++;
        end
        wr = 1'b0;
        rd = 1'b0;
        chk("t4_done", sent, 40);

        for (int i = 0; i < 8; i++) write_word(8'h30 + 8'(i));
        wr = 1'b1; rd = 1'b1; din = 8'h40;
`ifdef FIFO_FWFT_EN
        chk("t5_mid_dout", dout, 8'h30);
`endif
        tick();
        wr = 1'b0; rd = 1'b0;
`ifndef FIFO_FWFT_EN
        chk("t5_mid_dout", dout, 8'h30);
`endif
        chk("t5_mid_count", count, 8);
        for (int i = 0; i < 8; i++) write_word(8'h50 + 8'(i));
        chk("t5_full", full, 1);
        wr = 1'b1; rd = 1'b1; din = 8'hBB;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("t5_full_overflow", overflow, 1);
        chk("t5_full_count", count, 15);
        rd = 1'b1;
        repeat (15) tick();
        rd = 1'b0;
        chk("t5_drained", empty, 1);
        wr = 1'b1; rd = 1'b1; din = 8'h77;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("t5_empty_underflow", underflow, 1);
        chk("t5_empty_count", count, 1);
        read_word(8'h77, "t5_empty_data");

        write_word(8'h5A);
`ifdef FIFO_FWFT_EN
        chk("t6_fwft_dout", dout, 8'h5A);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t6_fwft_empty", empty, 1);
        chk("t6_fwft_dout0", dout, 0);
`else
        chk("t6_std_hold", dout, 8'h77);
        read_word(8'h5A, "t6_std_data");
        chk("t6_std_empty", empty, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
